// File: rtl/rect_cmd_arbiter.sv
// Two-requester round-robin arbiter feeding a rectangle-draw engine, with a per-frame grant budget.
// Optional per-requester grant and stall statistics are enabled by defining RECT_CMD_ARBITER_STATS_EN.
module rect_cmd_arbiter #(
  parameter int PIX_WIDTH          = 32,
  parameter int MAX_CMDS_PER_FRAME = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [1:0]           in_valid,
  output logic [1:0]           in_ready,
  input  logic [15:0]          in0_x,
  input  logic [15:0]          in0_y,
  input  logic [15:0]          in0_w,
  input  logic [15:0]          in0_h,
  input  logic [PIX_WIDTH-1:0] in0_color,
  input  logic [15:0]          in1_x,
  input  logic [15:0]          in1_y,
  input  logic [15:0]          in1_w,
  input  logic [15:0]          in1_h,
  input  logic [PIX_WIDTH-1:0] in1_color,
  output logic [15:0]          out_x,
  output logic [15:0]          out_y,
  output logic [15:0]          out_w,
  output logic [15:0]          out_h,
  output logic [PIX_WIDTH-1:0] out_color,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_grant_id,
  output logic                 budget_exhausted,
  output logic                 busy
`ifdef RECT_CMD_ARBITER_STATS_EN
  ,
  output logic [15:0]          stat_grants0,
  output logic [15:0]          stat_grants1,
  output logic [15:0]          stat_stall_cycles
`endif
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_CMDS_PER_FRAME);

  state_t               r_state;
  logic                 r_last_grant;
  logic [7:0]           r_count;
  logic                 r_out_valid;
  logic                 r_grant_id;
  logic [15:0]          r_x, r_y, r_w, r_h;
  logic [PIX_WIDTH-1:0] r_color;

  logic w_exhausted;
  logic w_grant;
  logic w_grant_id;

  assign w_exhausted = (r_count >= LP_MAX);
  assign w_grant     = (r_state == S_IDLE) && (|in_valid) && !w_exhausted;
  // On a tie the requester that did not win last time goes next.
  assign w_grant_id  = (&in_valid) ? ~r_last_grant : in_valid[1];

  assign in_ready         = (w_grant && !rst) ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign out_valid        = r_out_valid;
  assign out_grant_id     = r_grant_id;
  assign out_x            = r_x;
  assign out_y            = r_y;
  assign out_w            = r_w;
  assign out_h            = r_h;
  assign out_color        = r_color;
  assign budget_exhausted = w_exhausted;
  assign busy             = (r_state == S_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_count      <= 8'd0;
      r_out_valid  <= 1'b0;
      r_grant_id   <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_color      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state      <= S_ISSUE;
            r_out_valid  <= 1'b1;
            r_grant_id   <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_x          <= w_grant_id ? in1_x     : in0_x;
            r_y          <= w_grant_id ? in1_y     : in0_y;
            r_w          <= w_grant_id ? in1_w     : in0_w;
            r_h          <= w_grant_id ? in1_h     : in0_h;
            r_color      <= w_grant_id ? in1_color : in0_color;
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A grant coinciding with the frame boundary is the first of the new frame.
      if (frame_start)
        r_count <= w_grant ? 8'd1 : 8'd0;
      else if (w_grant)
        r_count <= r_count + 8'd1;
    end
  end

`ifdef RECT_CMD_ARBITER_STATS_EN
  logic [15:0] r_stat_g0, r_stat_g1, r_stat_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_g0    <= 16'd0;
      r_stat_g1    <= 16'd0;
      r_stat_stall <= 16'd0;
    end else begin
      if (w_grant && !w_grant_id) r_stat_g0 <= r_stat_g0 + 16'd1;
      if (w_grant &&  w_grant_id) r_stat_g1 <= r_stat_g1 + 16'd1;
      if ((|in_valid) && w_exhausted && (r_stat_stall != 16'hFFFF))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_grants0      = r_stat_g0;
  assign stat_grants1      = r_stat_g1;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_rect_cmd_arbiter.sv
// Scoreboard bench for rect_cmd_arbiter: a cycle model predicts grants and pushes expected commands,
// which are compared against the output command while it is presented and popped on handshake.
module tb_rect_cmd_arbiter;
  localparam int PW   = 32;
  localparam int MAXC = 3;

  typedef logic [96:0] cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [15:0]   in0_x, in0_y, in0_w, in0_h;
  logic [15:0]   in1_x, in1_y, in1_w, in1_h;
  logic [PW-1:0] in0_color, in1_color;
  logic [15:0]   out_x, out_y, out_w, out_h;
  logic [PW-1:0] out_color;
  logic          out_valid, out_ready, out_grant_id, budget_exhausted, busy;
`ifdef RECT_CMD_ARBITER_STATS_EN
  logic [15:0]   stat_grants0, stat_grants1, stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  rect_cmd_arbiter #(.PIX_WIDTH(PW), .MAX_CMDS_PER_FRAME(MAXC)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0_x(in0_x), .in0_y(in0_y), .in0_w(in0_w), .in0_h(in0_h), .in0_color(in0_color),
    .in1_x(in1_x), .in1_y(in1_y), .in1_w(in1_w), .in1_h(in1_h), .in1_color(in1_color),
    .out_x(out_x), .out_y(out_y), .out_w(out_w), .out_h(out_h), .out_color(out_color),
    .out_valid(out_valid), .out_ready(out_ready), .out_grant_id(out_grant_id),
    .budget_exhausted(budget_exhausted), .busy(busy)
`ifdef RECT_CMD_ARBITER_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  cmd_t sb_q[$];
  bit   m_issue;
  bit   m_last;
  int   m_count;
  int   m_g0, m_g1, m_stall;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic cmd_t req_cmd(input bit id);
    if (id) return {1'b1, in1_x, in1_y, in1_w, in1_h, in1_color};
    else    return {1'b0, in0_x, in0_y, in0_w, in0_h, in0_color};
  endfunction

  function automatic cmd_t out_cmd();
    return {out_grant_id, out_x, out_y, out_w, out_h, out_color};
  endfunction

  task automatic model_reset();
    m_issue = 1'b0; m_last = 1'b1; m_count = 0;
    m_g0 = 0; m_g1 = 0; m_stall = 0;
    sb_q.delete();
  endtask

  task automatic drive(input logic [1:0] v, input logic ordy, input logic fs);
    in_valid = v; out_ready = ordy; frame_start = fs;
    in0_x = 16'($urandom); in0_y = 16'($urandom); in0_w = 16'($urandom); in0_h = 16'($urandom);
    in1_x = 16'($urandom); in1_y = 16'($urandom); in1_w = 16'($urandom); in1_h = 16'($urandom);
    in0_color = $urandom; in1_color = $urandom;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit         exh, grant, gid;
    logic [1:0] exp_rdy;
    #1;
    exh     = (m_count >= MAXC);
    grant   = !m_issue && (in_valid != 2'b00) && !exh;
    gid     = (in_valid == 2'b11) ? ~m_last : in_valid[1];
    exp_rdy = grant ? (gid ? 2'b10 : 2'b01) : 2'b00;
    check("in_ready", 128'(in_ready), 128'(exp_rdy));
    check("out_valid", 128'(out_valid), 128'(m_issue));
    check("busy", 128'(busy), 128'(m_issue));
    check("budget_exhausted", 128'(budget_exhausted), 128'(exh));
    if (m_issue) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL cmd: got %h expected none (scoreboard empty)", out_cmd());
      end else begin
        check("cmd", 128'(out_cmd()), 128'(sb_q[0]));
      end
    end
    if (grant) sb_q.push_back(req_cmd(gid));
    @(posedge clk);
    if (m_issue && out_ready) begin
      m_issue = 1'b0;
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    if (grant) begin
      m_issue = 1'b1;
      m_last  = gid;
      if (gid) m_g1++; else m_g0++;
    end
    if (frame_start)  m_count = grant ? 1 : 0;
    else if (grant)   m_count++;
    if ((in_valid != 2'b00) && exh && m_stall < 65535) m_stall++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b0);
    #2;
    check("rst_in_ready", 128'(in_ready), 128'(2'b00));
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_budget", 128'(budget_exhausted), 128'(1'b0));
    check("rst_cmd", 128'(out_cmd()), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Tie after reset: 0,1,0,... with a frame boundary coinciding with a grant
    for (int i = 0; i < 12; i++) begin
      drive(2'b11, 1'b1, (i == 4) ? 1'b1 : 1'b0);
      cycle();
    end

    // Single request with fixed geometry
    drive(2'b00, 1'b1, 1'b1); cycle();
    drive(2'b01, 1'b1, 1'b0);
    in0_x = 16'd100; in0_y = 16'd100; in0_w = 16'd400; in0_h = 16'd400;
    cycle();
    for (int i = 0; i < 2; i++) begin drive(2'b00, 1'b1, 1'b0); cycle(); end

    // Back-pressure: ten cycles of out_ready low with both requesting
    drive(2'b01, 1'b1, 1'b1); cycle();
    for (int i = 0; i < 10; i++) begin drive(2'b11, 1'b0, 1'b0); cycle(); end
    for (int i = 0; i < 2; i++) begin drive(2'b00, 1'b1, 1'b0); cycle(); end

    // Budget: three grants, then stall until the next frame boundary
    drive(2'b00, 1'b1, 1'b1); cycle();
    for (int i = 0; i < 12; i++) begin drive(2'b11, 1'b1, 1'b0); cycle(); end
    drive(2'b11, 1'b1, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin drive(2'b11, 1'b1, 1'b0); cycle(); end

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      cycle();
    end

    // Reset during ISSUE
    for (int i = 0; i < 3; i++) begin drive(2'b00, 1'b1, 1'b0); cycle(); end
    drive(2'b01, 1'b0, 1'b1); cycle();
    drive(2'b00, 1'b0, 1'b0); cycle();
    #2 rst = 1'b1;
    #1;
    in_valid = 2'b11;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_in_ready", 128'(in_ready), 128'(2'b00));
    check("midrst_cmd", 128'(out_cmd()), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin drive(2'b11, 1'b1, 1'b0); cycle(); end

    // Stall accounting: exhaust the budget then hold requests for five cycles
    for (int i = 0; i < 2; i++) begin drive(2'b00, 1'b1, 1'b0); cycle(); end
    drive(2'b00, 1'b1, 1'b1); cycle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin drive(2'b11, 1'b1, 1'b0); cycle(); end
    drive(2'b00, 1'b1, 1'b0); cycle();
`ifdef RECT_CMD_ARBITER_STATS_EN
    check("stat_grants0", 128'(stat_grants0), 128'(m_g0));
    check("stat_grants1", 128'(stat_grants1), 128'(m_g1));
    check("stat_sum", 128'(stat_grants0 + stat_grants1), 128'(3));
    check("stat_stall_cycles", 128'(stat_stall_cycles), 128'(m_stall));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rect_cmd_arbiter.md
RECT_CMD_ARBITER -- requirements
Module: rect_cmd_arbiter

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 32, meaning color field width in bits.
REQ-002 SHALL have parameter MAX_CMDS_PER_FRAME, default 16, meaning the per-frame grant budget (range 1-255).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port frame_start, input, 1, meaning a one-cycle pulse at each frame boundary (vsync fall).
REQ-006 SHALL have port in_valid, input, 2, meaning per-requester command valid.
REQ-007 SHALL have port in_ready, output, 2, meaning per-requester command accept.
REQ-008 SHALL have ports in0_x, in0_y, in0_w, in0_h, input, 16 each, meaning the requester 0 rectangle; in1_x, in1_y, in1_w, in1_h are the same for requester 1.
REQ-009 SHALL have ports in0_color and in1_color, input, PIX_WIDTH, meaning the fill color per requester.
REQ-010 SHALL have ports out_x, out_y, out_w, out_h (16 each) and out_color (PIX_WIDTH), output, meaning the command to the rectangle-draw engine.
REQ-011 SHALL have port out_valid, output, 1, meaning the command is valid; and port out_ready, input, 1, meaning the draw engine is idle and accepts.
REQ-012 SHALL have port out_grant_id, output, 1, meaning the requester owning the current output command.
REQ-013 SHALL have port budget_exhausted, output, 1, meaning the frame grant count has reached MAX_CMDS_PER_FRAME.
REQ-014 SHALL have port busy, output, 1, meaning the state is ISSUE.

Function
REQ-015 SHALL implement two states: IDLE and ISSUE.
REQ-016 IDLE: when any in_valid is high and budget_exhausted=0, SHALL grant one requester, assert in_ready of that requester combinationally in the same cycle, latch its fields into the out_* registers, and enter ISSUE on the next cycle.
REQ-017 Arbitration SHALL be round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted last is granted.
REQ-018 ISSUE: out_valid SHALL be 1 and out_* SHALL be held stable until out_valid and out_ready are both high; the block SHALL then return to IDLE on the next cycle, with out_valid=0.
REQ-019 in_ready SHALL be 0 in ISSUE, and at most one in_ready bit SHALL be high in any cycle.
REQ-020 Latency SHALL be: in grant in cycle N gives out_valid=1 in cycle N+1; a handshake in cycle M allows a new grant no earlier than cycle M+1.
REQ-021 An 8-bit frame counter SHALL increment on each grant; budget_exhausted SHALL equal (count >= MAX_CMDS_PER_FRAME).
REQ-022 frame_start SHALL clear the counter to 0; when frame_start and a grant occur in the same cycle, the grant SHALL count in the new frame (count becomes 1).
REQ-023 When frame_start occurs in ISSUE, the current command SHALL complete unaffected.
REQ-024 When budget_exhausted=1, no grant SHALL occur; pending in_valid SHALL wait, without being dropped, until the next frame_start.
REQ-025 The block SHALL NOT require in_valid to stay asserted; a deasserted request is simply not considered.

Reset
REQ-026 On rst=1, state SHALL be IDLE; out_valid, in_ready, busy, budget_exhausted, out_grant_id, all out_* fields and the frame counter SHALL be 0; last-grant SHALL be 1, so requester 0 wins the first tie.
REQ-027 rst asserted mid-ISSUE SHALL abort the command immediately, with out_valid=0 asynchronously.

Configuration
REQ-028 With macro RECT_CMD_ARBITER_STATS_EN defined, the block SHALL add outputs stat_grants0 and stat_grants1 (16-bit each, counting grants per requester, wrapping at 65535->0, cleared by rst) and stat_stall_cycles (16-bit, counting cycles with any in_valid high while budget_exhausted=1, saturating at 65535).
REQ-029 Without RECT_CMD_ARBITER_STATS_EN, those ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Single request: in_valid=01, x=100, y=100, w=400, h=400, out_ready=1 -> in_ready=01 in cycle 0, out_valid=1 with identical fields in cycle 1, IDLE in cycle 2.
REQ-031 Tie after reset: in_valid=11 held, out_ready=1 -> grants in order 0,1,0,1; out_grant_id alternates.
REQ-032 Back-pressure: out_ready=0 for 10 cycles after a grant -> out_valid and out_* stable for 10 cycles, in_ready=00 throughout, handshake in cycle 11.
REQ-033 Budget: MAX_CMDS_PER_FRAME=3, continuous requests -> exactly 3 grants, then budget_exhausted=1 and no grant; frame_start -> counter=0 and grant resumes the next cycle.
REQ-034 Simultaneous events: frame_start in the same cycle as a grant -> counter=1 afterwards; rst pulse during ISSUE -> out_valid=0 immediately, and after release requester 0 wins the tie.
REQ-035 With RECT_CMD_ARBITER_STATS_EN, after REQ-033 with both requesters valid and 5 stalled cycles -> stat_grants0+stat_grants1=3 and stat_stall_cycles=5.
